// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared types and defaults for the pipeline sequencing controller.
//   mdu_state_e      : MDU busy-window FSM states (RUN, MDU_WAIT)
//   DEF_REG_ADDR_W   : default register-file address width
//   DEF_MDU_LATENCY  : default MDU busy window in cycles
//   ZERO_REG         : architectural $0, which can never carry a hazard
package pipe_pkg;

    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_MDU_LATENCY = 32;

    localparam logic [DEF_REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_busy_timer.sv
// mdu_busy_timer
// Tracks the multi-cycle multiply/divide unit. A qualified start loads the
// countdown with MDU_LATENCY; busy_o stays high while the count is nonzero.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   start_i : a mult/div is leaving ID this cycle (already qualified by the
//             caller against stall and flush)
//   busy_o  : MDU countdown nonzero
module mdu_busy_timer
    import pipe_pkg::*;
#(
    parameter int MDU_LATENCY = DEF_MDU_LATENCY,
    parameter int CNT_W       = $clog2(MDU_LATENCY + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o
);

    mdu_state_e       r_state;
    mdu_state_e       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;

    // State and countdown registers; reset abandons any countdown in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state logic. A start is only honoured from RUN, so the counter is
    // never reloaded while busy; the last count (1) returns the FSM to RUN.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            RUN: begin
                if (start_i) begin
                    w_nextState = MDU_WAIT;
                    w_nextCnt   = CNT_W'(MDU_LATENCY);
                end
            end
            MDU_WAIT: begin
                w_nextCnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = RUN;
                w_nextCnt   = '0;
            end
        endcase
    end

    assign busy_o = (r_state == MDU_WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Decides each
// cycle between flush (taken branch in EX), stall (RAW hazard with no
// forwarding, or HI/LO access while the MDU is busy) and run, and drives the
// PC / IF/ID / ID/EX controls accordingly.
// Ports:
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   id_rs_i, id_rt_i           : source registers of the ID instruction
//   id_uses_rs_i, id_uses_rt_i : ID instruction actually reads rs / rt
//   id_mdu_start_i             : ID holds mult/multu/div/divu
//   id_mdu_read_i              : ID holds mfhi/mflo/mthi/mtlo
//   ex_rd_i, ex_regwrite_i     : EX destination and write enable
//   mem_rd_i, mem_regwrite_i   : MEM destination and write enable
//   ex_branch_taken_i          : branch/jump in EX resolved taken
//   pc_ld_o                    : PC load enable
//   ifid_ld_o, ifid_clear_o    : IF/ID load / synchronous clear
//   idex_clear_o               : inject a bubble into ID/EX
//   stall_o                    : ID held this cycle
//   mdu_busy_o                 : MDU countdown nonzero
// Optional feature, macro PIPE_HAZARD_CTRL_STATS_EN: adds stall_cnt_o and
// flush_cnt_o, free-running 32-bit counts of stall and flush cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MDU_LATENCY = DEF_MDU_LATENCY,
    parameter int CNT_W       = $clog2(MDU_LATENCY + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_mdu_start_i,
    input  logic                  id_mdu_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  ex_regwrite_i,
    input  logic                  mem_regwrite_i,
    input  logic                  ex_branch_taken_i,
    output logic                  pc_ld_o,
    output logic                  ifid_ld_o,
    output logic                  ifid_clear_o,
    output logic                  idex_clear_o,
    output logic                  stall_o,
    output logic                  mdu_busy_o
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic w_exHit;
    logic w_memHit;
    logic w_rawHit;
    logic w_mduHit;
    logic w_flush;
    logic w_stall;
    logic w_mduStart;
    logic w_mduBusy;

    // A producer only matters if it writes a real register; $0 is hardwired.
    // WB is absent because the register file writes in the first half-cycle.
    assign w_exHit  = ex_regwrite_i && (ex_rd_i != ZERO_ADDR) &&
                      ((id_uses_rs_i && (id_rs_i == ex_rd_i)) ||
                       (id_uses_rt_i && (id_rt_i == ex_rd_i)));
    assign w_memHit = mem_regwrite_i && (mem_rd_i != ZERO_ADDR) &&
                      ((id_uses_rs_i && (id_rs_i == mem_rd_i)) ||
                       (id_uses_rt_i && (id_rt_i == mem_rd_i)));
    assign w_rawHit = w_exHit || w_memHit;

    // Any HI/LO access, including a second mult/div, waits out the window.
    assign w_mduHit = w_mduBusy && (id_mdu_read_i || id_mdu_start_i);

    assign w_flush = ex_branch_taken_i;
    assign w_stall = (w_rawHit || w_mduHit) && !w_flush;

    // A stalled or squashed mult/div has not left ID, so it must not start
    // the countdown.
    assign w_mduStart = id_mdu_start_i && !w_stall && !w_flush;

    mdu_busy_timer #(
        .MDU_LATENCY (MDU_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mduBusyTimer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_mduStart),
        .busy_o  (w_mduBusy)
    );

    assign mdu_busy_o = w_mduBusy;

    // Control decode, priority reset > flush > stall > run. During flush the
    // IF/ID clear dominates the load, so the load is left asserted.
    always_comb begin
        pc_ld_o      = 1'b1;
        ifid_ld_o    = 1'b1;
        ifid_clear_o = 1'b0;
        idex_clear_o = 1'b0;
        stall_o      = 1'b0;
        if (rst_i) begin
            pc_ld_o      = 1'b0;
            ifid_ld_o    = 1'b0;
            ifid_clear_o = 1'b1;
            idex_clear_o = 1'b1;
        end else if (w_flush) begin
            ifid_clear_o = 1'b1;
            idex_clear_o = 1'b1;
        end else if (w_stall) begin
            pc_ld_o      = 1'b0;
            ifid_ld_o    = 1'b0;
            idex_clear_o = 1'b1;
            stall_o      = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;

    // Event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stall) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_flush) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl with MDU_LATENCY=4. Each vector
// drives the ID/EX/MEM view of the pipeline by hand and compares the packed
// control word {pc_ld, ifid_ld, ifid_clear, idex_clear, stall, mdu_busy}
// against a hand-computed value.
module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] idRs;
    logic [AW-1:0] idRt;
    logic          idUsesRs;
    logic          idUsesRt;
    logic          idMduStart;
    logic          idMduRead;
    logic [AW-1:0] exRd;
    logic [AW-1:0] memRd;
    logic          exRegwrite;
    logic          memRegwrite;
    logic          exBranchTaken;
    logic          pcLd;
    logic          ifidLd;
    logic          ifidClear;
    logic          idexClear;
    logic          stall;
    logic          mduBusy;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [31:0]   stallCnt;
    logic [31:0]   flushCnt;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    // Control-word constants: {pc_ld, ifid_ld, ifid_clear, idex_clear, stall, busy}
    localparam logic [5:0] V_RESET      = 6'b001100;
    localparam logic [5:0] V_RUN        = 6'b110000;
    localparam logic [5:0] V_STALL      = 6'b000110;
    localparam logic [5:0] V_FLUSH      = 6'b111100;
    localparam logic [5:0] V_RUN_BUSY   = 6'b110001;
    localparam logic [5:0] V_STALL_BUSY = 6'b000111;
    localparam logic [5:0] V_FLUSH_BUSY = 6'b111101;

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (AW),
        .MDU_LATENCY (LAT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs_i           (idRs),
        .id_rt_i           (idRt),
        .id_uses_rs_i      (idUsesRs),
        .id_uses_rt_i      (idUsesRt),
        .id_mdu_start_i    (idMduStart),
        .id_mdu_read_i     (idMduRead),
        .ex_rd_i           (exRd),
        .mem_rd_i          (memRd),
        .ex_regwrite_i     (exRegwrite),
        .mem_regwrite_i    (memRegwrite),
        .ex_branch_taken_i (exBranchTaken),
        .pc_ld_o           (pcLd),
        .ifid_ld_o         (ifidLd),
        .ifid_clear_o      (ifidClear),
        .idex_clear_o      (idexClear),
        .stall_o           (stall),
        .mdu_busy_o        (mduBusy)
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        ,
        .stall_cnt_o       (stallCnt),
        .flush_cnt_o       (flushCnt)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a broken run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, actual, expected);
        end
    endtask

    // Compares the packed control word. Flush leaves ifid_ld undefined by
    // intent (the clear dominates), so that bit can be masked out.
    task automatic checkCtl(input string tag, input logic [5:0] expected,
                            input bit maskIfidLd);
        logic [5:0] actual;
        logic [5:0] want;
        actual = {pcLd, ifidLd, ifidClear, idexClear, stall, mduBusy};
        want   = expected;
        if (maskIfidLd) begin
            actual[4] = 1'b0;
            want[4]   = 1'b0;
        end
        checkOutput(tag, 32'(actual), 32'(want));
    endtask

    // Drives one cycle's worth of pipeline inputs.
    task automatic applyStimulus(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic usesRs, input logic usesRt,
                                 input logic mduStart, input logic mduRead,
                                 input logic [AW-1:0] eRd, input logic eRw,
                                 input logic [AW-1:0] mRd, input logic mRw,
                                 input logic branch);
        idRs          = rs;
        idRt          = rt;
        idUsesRs      = usesRs;
        idUsesRt      = usesRt;
        idMduStart    = mduStart;
        idMduRead     = mduRead;
        exRd          = eRd;
        exRegwrite    = eRw;
        memRd         = mRd;
        memRegwrite   = mRw;
        exBranchTaken = branch;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        checkCtl("reset_idle", V_RESET, 1'b0);

        // A RAW hazard must not raise stall_o while reset is held.
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("reset_raw", V_RESET, 1'b0);

        nextCycle();
        rst = 1'b0;
        idle();
        #1;
        checkCtl("run_idle", V_RUN, 1'b0);
        nextCycle();

        // RAW on EX: two stall cycles (EX, then MEM), then run.
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("raw_ex_c1", V_STALL, 1'b0);
        nextCycle();
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1;
        checkCtl("raw_ex_c2_mem", V_STALL, 1'b0);
        nextCycle();
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("raw_ex_c3_run", V_RUN, 1'b0);
        nextCycle();

        // $0 as destination never hazards.
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        checkCtl("zero_reg", V_RUN, 1'b0);
        nextCycle();

        // rt path against MEM, then the same match with rt not read.
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        checkCtl("raw_mem_rt", V_STALL, 1'b0);
        nextCycle();
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        checkCtl("rt_unused", V_RUN, 1'b0);
        nextCycle();

        // RAW stall coinciding with a taken branch: flush wins.
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1);
        #1;
        checkCtl("flush_over_raw", V_FLUSH, 1'b1);
        nextCycle();

        // div in ID while the branch flushes: squashed, no busy window.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        checkCtl("div_squash", V_FLUSH, 1'b1);
        nextCycle();
        idle();
        #1;
        checkCtl("div_squash_nobusy", V_RUN, 1'b0);
        nextCycle();

        // mult leaves ID, then four busy cycles with flush and a second
        // mult mixed in; the flush must not disturb the countdown.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("mult_issue", V_RUN, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("mflo_busy1", V_STALL_BUSY, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        checkCtl("flush_busy2", V_FLUSH_BUSY, 1'b1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("mult_busy3", V_STALL_BUSY, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("mflo_busy4", V_STALL_BUSY, 1'b0);
        nextCycle();
        #1;
        checkCtl("mflo_released", V_RUN, 1'b0);
        nextCycle();

        // With nothing pending, the busy window never reappeared.
        idle();
        #1;
        checkCtl("idle_after_mdu", V_RUN, 1'b0);

`ifdef PIPE_HAZARD_CTRL_STATS_EN
        // Stalls: raw_ex x2, raw_mem_rt, mflo_busy1, mult_busy3, mflo_busy4.
        // Flushes: flush_over_raw, div_squash, flush_busy2.
        checkOutput("stall_cnt", stallCnt, 32'd6);
        checkOutput("flush_cnt", flushCnt, 32'd3);
`endif
        nextCycle();

        // Reset in the middle of a busy window (counter at 2).
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("mult2_issue", V_RUN, 1'b0);
        nextCycle();
        idle();
        #1;
        checkCtl("mult2_busy_c4", V_RUN_BUSY, 1'b0);
        nextCycle();
        #1;
        checkCtl("mult2_busy_c3", V_RUN_BUSY, 1'b0);
        nextCycle();
        rst = 1'b1;
        #1;
        checkCtl("reset_mid_wait", V_RESET, 1'b0);
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        checkOutput("stall_cnt_rst", stallCnt, 32'd0);
        checkOutput("flush_cnt_rst", flushCnt, 32'd0);
`endif
        nextCycle();
        rst = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkCtl("mflo_after_reset", V_RUN, 1'b0);
        nextCycle();
        #1;
        checkCtl("mflo_after_reset2", V_RUN, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
